// File: rtl/serial_word_gather_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_gather_pkg
//  Description : Shared constants, index type and serial-bit placement helper
//                for the serial word gatherer.
//                Optional feature macro: SERIAL_WORD_GATHER_MSB_FIRST_EN
//                (defined: the first serial bit lands in the word MSB).
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_word_gather_pkg;

    localparam int DEFAULT_WIDTH = 128;

`ifdef SERIAL_WORD_GATHER_MSB_FIRST_EN
    localparam bit c_msb_first = 1'b1;
`else
    localparam bit c_msb_first = 1'b0;
`endif

    // Bit index type for the default word width
    typedef logic [$clog2(DEFAULT_WIDTH)-1:0] idx_t;

    // Word position that serial bit number i is written to
    function automatic int unsigned pos(input int unsigned width, input int unsigned i);
        return c_msb_first ? (width - 1 - i) : i;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_word_gather_outreg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_gather_outreg
//  Description : WIDTH-bit valid/ready output holding register. A load in the
//                same cycle as a consumer accept replaces the word and keeps
//                valid asserted, so word boundaries need no bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_gather_outreg
    import serial_word_gather_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid
);

    logic [WIDTH-1:0] word_q, word_d;
    logic             vld_q, vld_d;

    // Next-state: load has priority over a drain so a fresh word never bubbles
    always_comb begin
        word_d = word_q;
        vld_d  = vld_q;
        if (load) begin
            word_d = load_data;
            vld_d  = 1'b1;
        end else if (vld_q && word_ready) begin
            vld_d  = 1'b0;
        end
    end

    // Holding register with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            vld_q  <= vld_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = vld_q;

endmodule
`default_nettype wire

// File: rtl/serial_word_gather.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_gather
//  Description : Serial-to-parallel gatherer. One bit per valid/ready
//                handshake is written into an assembly buffer; every WIDTH
//                bits the completed word is moved to a valid/ready output
//                holding register while the next word keeps assembling.
//                Optional feature macro: SERIAL_WORD_GATHER_MSB_FIRST_EN
//                (defined: first serial bit lands in word_out[WIDTH-1]).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_gather
    import serial_word_gather_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    output logic                     bit_ready,
    output logic [WIDTH-1:0]         word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(WIDTH)-1:0] fill_count
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] asm_q, asm_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             w_accept;
    logic             w_last;
    logic             w_load;
    logic [IDX_W-1:0] w_pos;

    assign w_last    = (idx_q == IDX_W'(WIDTH - 1));
    // Only the final bit can stall, and only while the output is full and not draining
    assign bit_ready = !(w_last && word_valid && !word_ready);
    assign w_accept  = bit_valid && bit_ready;
    assign w_pos     = IDX_W'(pos(WIDTH, 32'(idx_q)));
    assign fill_count = idx_q;

    // Next-state: place the accepted bit, advance the index, hand off full words
    always_comb begin
        asm_d  = asm_q;
        idx_d  = idx_q;
        w_load = 1'b0;
        if (clear) begin
            // Clear drops any bit accepted this cycle; the pending output word is untouched
            idx_d = '0;
        end else if (w_accept) begin
            asm_d[w_pos] = bit_in;
            if (w_last) begin
                idx_d  = '0;
                w_load = 1'b1;
            end else begin
                idx_d  = idx_q + IDX_W'(1);
            end
        end
    end

    // Assembly buffer and index; stale buffer bits are simply overwritten by the next word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q <= '0;
            idx_q <= '0;
        end else begin
            asm_q <= asm_d;
            idx_q <= idx_d;
        end
    end

    serial_word_gather_outreg #(
        .WIDTH (WIDTH)
    ) u_outreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_load),
        .load_data  (asm_d),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid)
    );

endmodule
`default_nettype wire
